// File: rtl/button_pkg.sv
`timescale 1ns/1ps
// button_pkg: shared FSM state type, counter sizing helper and default gesture timings for the button path
package button_pkg;
    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND_HELD} press_state_t;
    localparam int DEF_LONG_CYCLES       = 50_000_000;
    localparam int DEF_DOUBLE_GAP_CYCLES = 15_000_000;
    localparam int DEF_REPEAT_CYCLES     = 10_000_000;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/button_press_classifier_press_timer.sv
`timescale 1ns/1ps
// press_timer: saturating counter with clear/enable and a terminal-match flag
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : restart from 0 this cycle (combined with i_en gives 1)
//   i_en       : count up by one, holding at all-ones
//   i_target   : compare value
//   o_match    : current count equals i_target
module press_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_target,
    output logic         o_match
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_base;
    assign w_base = i_clr ? '0 : r_cnt;
    always_ff @(posedge clk)
        r_cnt <= !rst_n ? '0 : (i_en && w_base != '1) ? w_base + W'(1) : w_base;
    assign o_match = r_cnt == i_target;
endmodule

// File: rtl/button_press_classifier.sv
`timescale 1ns/1ps
// button_press_classifier: turns a debounced button level into short/long/double gestures
//   clk, rst_n   : clock, synchronous active-low reset
//   state        : debounced, clk-synchronous button level
//   short_press  : pulse, single press confirmed after the double-press window
//   long_press   : pulse, hold reached LONG_CYCLES
//   double_press : pulse, second press began inside the gap window
//   long_held    : level, button still held after a long press
//   repeat_tick  : pulse every REPEAT_CYCLES while long-held (BUTTON_REPEAT_EN), else 0
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES       = DEF_LONG_CYCLES,
    parameter int DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic state,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic long_held,
    output logic repeat_tick
);
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam int W = cnt_width(LONG_CYCLES, DOUBLE_GAP_CYCLES, REP_EN ? REPEAT_CYCLES : 0);
    press_state_t r_state, w_next;
    logic         w_match, w_clr, w_en, w_rep_hit;
    logic [W-1:0] w_target;
    logic         w_short, w_long, w_double, w_held;
    logic         r_short, r_long, r_double, r_held;
    always_ff @(posedge clk)
        r_state <= !rst_n ? IDLE : w_next;
    // a rising edge inside GAP wins over the timeout on the same sample
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        w_next = state ? PRESSED : IDLE;
            PRESSED:     w_next = !state ? GAP : w_match ? LONG_HELD : PRESSED;
            LONG_HELD:   w_next = state ? LONG_HELD : IDLE;
            GAP:         w_next = state ? SECOND_HELD : w_match ? IDLE : GAP;
            SECOND_HELD: w_next = state ? SECOND_HELD : IDLE;
            default:     w_next = IDLE;
        endcase
    end
    // PRESSED matches one early so long_press lands LONG_CYCLES edges after the press;
    // LONG_HELD starts at 0 and ticks on REPEAT_CYCLES-1, then restarts.
    always_comb begin
        w_target  = r_state == PRESSED   ? W'(LONG_CYCLES - 1) :
                    r_state == GAP       ? W'(DOUBLE_GAP_CYCLES) :
                    r_state == LONG_HELD && REP_EN ? W'(REPEAT_CYCLES - 1) : '0;
        w_short   = r_state == GAP && !state && w_match;
        w_long    = r_state == PRESSED && state && w_match;
        w_double  = r_state == GAP && state;
        w_held    = r_state == LONG_HELD && state;
        w_rep_hit = REP_EN && w_held && w_match;
        w_clr     = w_next != r_state || w_rep_hit;
        w_en      = (r_state == IDLE && state) || (r_state == PRESSED && !w_long) ||
                    (r_state == GAP && !state) || (REP_EN && w_held && !w_match);
    end
    press_timer #(.W(W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_target (w_target),
        .o_match  (w_match)
    );
    always_ff @(posedge clk)
        {r_short, r_long, r_double, r_held} <= !rst_n ? 4'b0 : {w_short, w_long, w_double, w_held};
    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign long_held    = r_held;
`ifdef BUTTON_REPEAT_EN
    logic r_tick;
    always_ff @(posedge clk)
        r_tick <= rst_n && w_rep_hit;
    assign repeat_tick = r_tick;
`else
    assign repeat_tick = 1'b0;
`endif
endmodule

// File: tb/tb_button_press_classifier.sv
`timescale 1ns/1ps
// tb_button_press_classifier: scoreboard bench for the gesture classifier
module tb_button_press_classifier;
    localparam int L = 20;
    localparam int G = 8;
    localparam int R = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic state = 1'b0;
    logic short_press, long_press, double_press, long_held, repeat_tick;
    button_press_classifier #(.LONG_CYCLES(L), .DOUBLE_GAP_CYCLES(G), .REPEAT_CYCLES(R)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .long_held    (long_held),
        .repeat_tick  (repeat_tick)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    logic [4:0] q[$];
    int m = 0, hi = 0, lo = 0, rep = 0;
    int t = 0, t0 = 0;
    int n_sp, n_lp, n_dp, n_lh, n_rt;
    int sp_t, lp_t, dp_t, lh_t, rt_t;
    string tname = "rst";
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // reference: run-length view of the gesture; m 0 idle,1 high run,2 long,3 low run,4 second press
    task automatic model(input logic s, input logic rn);
        logic sp, lp, dp, lh, rt;
        {sp, lp, dp, lh, rt} = 5'b0;
        if (!rn) m = 0;
        else case (m)
            0: if (s) begin m = 1; hi = 1; end
            1: if (s) begin
                   hi++;
                   if (hi == L) begin lp = 1; m = 2; rep = 0; end
               end else begin m = 3; lo = 1; end
            2: if (s) begin
                   lh = 1;
`ifdef BUTTON_REPEAT_EN
                   rep++;
                   if (rep == R) begin rt = 1; rep = 0; end
`endif
               end else m = 0;
            3: if (s) begin dp = 1; m = 4; end
               else begin
                   lo++;
                   if (lo == G + 1) begin sp = 1; m = 0; end
               end
            default: if (!s) m = 0;
        endcase
        q.push_back({sp, lp, dp, lh, rt});
    endtask
    task automatic cyc(input logic s, input logic rn);
        logic [4:0] exp;
        @(negedge clk);
        t++;
        if (q.size() != 0) begin
            exp = q.pop_front();
            check($sformatf("%s_outs@%0d", tname, t - t0), {short_press, long_press, double_press, long_held, repeat_tick}, exp);
            if (short_press)  begin n_sp++; if (sp_t < 0) sp_t = t; end
            if (long_press)   begin n_lp++; if (lp_t < 0) lp_t = t; end
            if (double_press) begin n_dp++; if (dp_t < 0) dp_t = t; end
            if (long_held)    begin n_lh++; if (lh_t < 0) lh_t = t; end
            if (repeat_tick)  begin n_rt++; if (rt_t < 0) rt_t = t; end
        end
        state = s;
        rst_n = rn;
        model(s, rn);
    endtask
    task automatic run(input logic s, input int n);
        for (int i = 0; i < n; i++) cyc(s, 1'b1);
    endtask
    task automatic begin_test(input string name);
        tname = name;
        t0 = t + 1;
        {n_sp, n_lp, n_dp, n_lh, n_rt} = '0;
        {sp_t, lp_t, dp_t, lh_t, rt_t} = {5{-1}};
    endtask
    initial begin
        begin_test("rst");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        check("rst_outs", {short_press, long_press, double_press, long_held, repeat_tick}, 0);
        run(1'b0, 2);
        begin_test("short");
        run(1'b1, 5);
        run(1'b0, 15);
        check("short_n", n_sp, 1);
        check("short_at", sp_t - t0, 14);
        check("short_other", n_lp + n_dp + n_lh + n_rt, 0);
        begin_test("long");
        run(1'b1, 30);
        run(1'b0, 5);
        check("long_n", n_lp, 1);
        check("long_at", lp_t - t0, 20);
        check("long_held_n", n_lh, 10);
        check("long_held_at", lh_t - t0, 21);
        check("long_noshort", n_sp + n_dp, 0);
        begin_test("below_long");
        run(1'b1, 19);
        run(1'b0, 15);
        check("below_long_lp", n_lp, 0);
        check("below_long_sp", n_sp, 1);
        begin_test("double");
        run(1'b1, 4);
        run(1'b0, 3);
        run(1'b1, 4);
        run(1'b0, 15);
        check("double_n", n_dp, 1);
        check("double_at", dp_t - t0, 8);
        check("double_noshort", n_sp + n_lp, 0);
        begin_test("tie");
        run(1'b1, 4);
        run(1'b0, 8);
        run(1'b1, 3);
        run(1'b0, 15);
        check("tie_dp", n_dp, 1);
        check("tie_sp", n_sp, 0);
        begin_test("second_hold");
        run(1'b1, 3);
        run(1'b0, 2);
        run(1'b1, 30);
        run(1'b0, 15);
        check("second_hold_dp", n_dp, 1);
        check("second_hold_lp", n_lp + n_lh + n_sp, 0);
        begin_test("midrst");
        run(1'b1, 4);
        run(1'b0, 3);
        cyc(1'b0, 1'b0);
        run(1'b0, 15);
        check("midrst_pulses", n_sp + n_lp + n_dp + n_lh + n_rt, 0);
        begin_test("after_rst");
        run(1'b1, 3);
        run(1'b0, 15);
        check("after_rst_sp", n_sp, 1);
        check("after_rst_at", sp_t - t0, 12);
        begin_test("repeat");
        run(1'b1, 40);
        run(1'b0, 5);
        check("repeat_lp_at", lp_t - t0, 20);
        check("repeat_lh_n", n_lh, 20);
`ifdef BUTTON_REPEAT_EN
        check("repeat_n", n_rt, 4);
        check("repeat_at", rt_t - t0, 25);
`else
        check("repeat_n", n_rt, 0);
`endif
        run(1'b0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
